// File: rtl/ga_issue_unit.sv
// ga_issue_unit: core-side initiator for the GA coprocessor request/response protocol.
// Issues one instruction at a time, absorbs the two-cycle response hold and returns one result.
package ga_pkg;
  typedef enum logic [2:0] {GA_ADD, GA_SUB, GA_MUL, GA_DOT, GA_WEDGE, GA_RSVD = 3'h7} ga_funct_e;
  typedef struct packed {
    logic        valid;
    ga_funct_e   funct;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  ga_reg_a;
    logic [4:0]  ga_reg_b;
    logic [4:0]  rd;
    logic        we;
    logic        use_ga_regs;
  } ga_req_t;
  typedef struct packed {
    logic        ready;
    logic        valid;
    logic [31:0] result;
    logic        error;
    logic        busy;
    logic        overflow;
    logic        underflow;
  } ga_resp_t;
endpackage

module ga_issue_unit
  import ga_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  input  ga_funct_e   instr_funct_i,
  input  logic [31:0] instr_op_a_i,
  input  logic [31:0] instr_op_b_i,
  input  logic [4:0]  instr_ga_reg_a_i,
  input  logic [4:0]  instr_ga_reg_b_i,
  input  logic [4:0]  instr_rd_i,
  input  logic        instr_we_i,
  input  logic        instr_use_ga_regs_i,
  input  logic        kill_i,
  output ga_req_t     ga_req_o,
  input  ga_resp_t    ga_resp_i,
  output logic        result_valid_o,
  input  logic        result_ready_i,
  output logic [31:0] result_o,
  output logic [4:0]  result_rd_o,
  output logic        result_err_o,
  output logic        result_timeout_o,
  output logic        busy_o,
  output logic [31:0] issued_cnt_o,
  output logic [15:0] timeout_cnt_o,
  output logic [15:0] spurious_cnt_o
);
  localparam int unsigned TW = $clog2(TimeoutCycles);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  state_e state_q;
  logic drain_q, discard_q, discard, tmo_hit, accept, unused_resp;
  logic [TW-1:0] tmo_q;
  assign instr_ready_o = state_q == IDLE && !kill_i;
  assign accept = instr_valid_i && instr_ready_o;
  // a kill arriving in the same cycle as the response still suppresses the result
  assign discard = discard_q || kill_i;
  assign tmo_hit = tmo_q == TW'(TimeoutCycles - 1);
  assign busy_o = state_q != IDLE;
  assign unused_resp = ^{ga_resp_i.busy, ga_resp_i.overflow, ga_resp_i.underflow};
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= IDLE;
      drain_q          <= 1'b0;
      discard_q        <= 1'b0;
      tmo_q            <= '0;
      ga_req_o         <= '0;
      result_valid_o   <= 1'b0;
      result_o         <= '0;
      result_rd_o      <= '0;
      result_err_o     <= 1'b0;
      result_timeout_o <= 1'b0;
      issued_cnt_o     <= '0;
      timeout_cnt_o    <= '0;
      spurious_cnt_o   <= '0;
    end else begin
      drain_q <= 1'b0;
      if (ga_resp_i.valid && state_q != WAIT && !drain_q) spurious_cnt_o <= spurious_cnt_o + 16'd1;
      case (state_q)
        IDLE: if (accept) begin
          ga_req_o <= '{valid: 1'b1, funct: instr_funct_i, op_a: instr_op_a_i, op_b: instr_op_b_i,
                        ga_reg_a: instr_ga_reg_a_i, ga_reg_b: instr_ga_reg_b_i, rd: instr_rd_i,
                        we: instr_we_i, use_ga_regs: instr_use_ga_regs_i};
          state_q  <= ISSUE;
        end
        // once the coprocessor has taken the request its response must be awaited even if killed
        ISSUE: if (ga_resp_i.ready) begin
          ga_req_o.valid <= 1'b0;
          issued_cnt_o   <= issued_cnt_o + 32'd1;
          tmo_q          <= '0;
          discard_q      <= kill_i;
          state_q        <= WAIT;
        end else if (kill_i) begin
          ga_req_o.valid <= 1'b0;
          state_q        <= IDLE;
        end
        WAIT: if (ga_resp_i.valid || tmo_hit) begin
          result_o         <= ga_resp_i.valid ? ga_resp_i.result : 32'd0;
          result_err_o     <= ga_resp_i.valid ? ga_resp_i.error : 1'b1;
          result_timeout_o <= !ga_resp_i.valid;
          result_rd_o      <= ga_req_o.rd;
          result_valid_o   <= !discard;
          drain_q          <= ga_resp_i.valid && !ga_resp_i.error;
          timeout_cnt_o    <= ga_resp_i.valid ? timeout_cnt_o : timeout_cnt_o + 16'd1;
          discard_q        <= 1'b0;
          state_q          <= discard ? IDLE : RESP;
        end else begin
          tmo_q     <= tmo_q + 1'b1;
          discard_q <= discard;
        end
        RESP: if (result_ready_i || kill_i) begin
          result_valid_o <= 1'b0;
          state_q        <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ga_issue_unit.sv
// tb_ga_issue_unit: directed plus randomized transactions against a transaction-level model
module tb_ga_issue_unit;
  import ga_pkg::*;
  localparam int T = 8;
  localparam int M_NORM = 0, M_TMO = 1, M_KISSUE = 2, M_KWAIT = 3, M_KRESP = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic instr_valid, instr_ready, we, use_ga, kill;
  ga_funct_e instr_funct;
  logic [31:0] op_a, op_b, result;
  logic [4:0] reg_a, reg_b, rd, result_rd;
  ga_req_t ga_req;
  ga_resp_t ga_resp;
  logic result_valid, result_ready, result_err, result_timeout, busy;
  logic [31:0] issued_cnt;
  logic [15:0] timeout_cnt, spurious_cnt;
  int tests = 0, fails = 0;
  logic [31:0] exp_issued = '0;
  logic [15:0] exp_tmo = '0, exp_spur = '0;
  bit err_echo = 1'b0;

  always #5 clk = ~clk;

  ga_issue_unit #(.TimeoutCycles(T)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_valid_i(instr_valid), .instr_ready_o(instr_ready), .instr_funct_i(instr_funct),
    .instr_op_a_i(op_a), .instr_op_b_i(op_b), .instr_ga_reg_a_i(reg_a), .instr_ga_reg_b_i(reg_b),
    .instr_rd_i(rd), .instr_we_i(we), .instr_use_ga_regs_i(use_ga), .kill_i(kill),
    .ga_req_o(ga_req), .ga_resp_i(ga_resp),
    .result_valid_o(result_valid), .result_ready_i(result_ready), .result_o(result),
    .result_rd_o(result_rd), .result_err_o(result_err), .result_timeout_o(result_timeout),
    .busy_o(busy), .issued_cnt_o(issued_cnt), .timeout_cnt_o(timeout_cnt), .spurious_cnt_o(spurious_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] e);
    tests++;
    if (obs !== e) begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
    end
  endtask

  function automatic logic [31:0] ref_op(input ga_funct_e f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      GA_ADD:  return a + b;
      GA_SUB:  return a - b;
      GA_MUL:  return a * b;
      default: return a ^ b;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt();
    chk("issued_cnt", issued_cnt, exp_issued);
    chk("timeout_cnt", timeout_cnt, exp_tmo);
    chk("spurious_cnt", spurious_cnt, exp_spur);
  endtask

  task automatic run(input ga_funct_e f, input logic [31:0] a, input logic [31:0] b,
                     input int mode, input int stall, input int delay, input int rwait);
    ga_req_t exp_req;
    logic is_err;
    logic [31:0] exp_res;
    is_err = f == GA_RSVD;
    exp_res = ref_op(f, a, b);
    exp_req = '{valid: 1'b1, funct: f, op_a: a, op_b: b, ga_reg_a: 5'($urandom), ga_reg_b: 5'($urandom),
                rd: 5'($urandom), we: 1'($urandom), use_ga_regs: 1'($urandom)};
    instr_funct = f; op_a = a; op_b = b; reg_a = exp_req.ga_reg_a; reg_b = exp_req.ga_reg_b;
    rd = exp_req.rd; we = exp_req.we; use_ga = exp_req.use_ga_regs;
    instr_valid = 1'b1;
    #1 chk("instr_ready_idle", instr_ready, 1'b1);
    step();
    instr_valid = 1'b0; op_a = $urandom; op_b = $urandom;
    for (int i = 0; i <= stall; i++) begin
      chk("req_hold", ga_req, exp_req);
      kill = mode == M_KISSUE && i == stall;
      ga_resp.ready = mode != M_KISSUE && i == stall;
      step();
    end
    kill = 1'b0; ga_resp.ready = 1'b0;
    chk("req_valid_drop", ga_req.valid, 1'b0);
    if (mode == M_KISSUE) begin
      chk("kill_issue_idle", busy, 1'b0);
      chk("kill_issue_nores", result_valid, 1'b0);
    end else if (mode == M_TMO) begin
      exp_issued++;
      for (int w = 0; w < T; w++) begin
        chk("tmo_wait", result_valid, 1'b0);
        step();
      end
      exp_tmo++;
      chk("tmo_valid", result_valid, 1'b1);
      chk("tmo_err", result_err, 1'b1);
      chk("tmo_flag", result_timeout, 1'b1);
      chk("tmo_result", result, 32'd0);
      chk("tmo_rd", result_rd, exp_req.rd);
      ga_resp.valid = 1'b1; result_ready = 1'b1;
      step();
      ga_resp.valid = 1'b0; result_ready = 1'b0;
      exp_spur++;
      chk("tmo_done", result_valid, 1'b0);
    end else begin
      exp_issued++;
      for (int w = 0; w <= delay; w++) begin
        chk("wait_nores", result_valid, 1'b0);
        kill = mode == M_KWAIT && w == 0;
        ga_resp.valid = w == delay; ga_resp.result = exp_res; ga_resp.error = is_err;
        step();
      end
      kill = 1'b0;
      ga_resp.valid = !is_err || err_echo;
      if (is_err && err_echo) exp_spur++;
      if (mode == M_KWAIT) begin
        chk("kwait_nores", result_valid, 1'b0);
        chk("kwait_idle", busy, 1'b0);
        step();
        ga_resp.valid = 1'b0;
        chk("kwait_nores2", result_valid, 1'b0);
      end else begin
        chk("res_valid", result_valid, 1'b1);
        chk("res_value", result, exp_res);
        chk("res_rd", result_rd, exp_req.rd);
        chk("res_err", result_err, is_err);
        chk("res_tmo", result_timeout, 1'b0);
        if (mode == M_KRESP) begin
          kill = 1'b1;
          step();
          kill = 1'b0; ga_resp.valid = 1'b0;
          chk("kresp_drop", result_valid, 1'b0);
          chk("kresp_idle", busy, 1'b0);
        end else begin
          for (int k = 0; k < rwait; k++) begin
            step();
            ga_resp.valid = 1'b0;
            chk("res_hold_valid", result_valid, 1'b1);
            chk("res_hold_value", result, exp_res);
          end
          result_ready = 1'b1;
          step();
          ga_resp.valid = 1'b0; result_ready = 1'b0;
          chk("res_done", result_valid, 1'b0);
          chk("res_idle", busy, 1'b0);
        end
      end
    end
    chk_cnt();
  endtask

  task automatic chk_reset();
    chk("rst_req", ga_req, ga_req_t'('0));
    chk("rst_rvalid", result_valid, 1'b0);
    chk("rst_err", result_err, 1'b0);
    chk("rst_tmo", result_timeout, 1'b0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd", result_rd, 5'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", instr_ready, 1'b1);
    chk_cnt();
  endtask

  initial begin
    instr_valid = 1'b0; instr_funct = GA_ADD; op_a = '0; op_b = '0; reg_a = '0; reg_b = '0; rd = '0;
    we = 1'b0; use_ga = 1'b0; kill = 1'b0; ga_resp = '0; result_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_reset();
    rst_n = 1'b1;
    step();
    run(GA_ADD, 32'd3, 32'd4, M_NORM, 0, 0, 0);
    err_echo = 1'b1;
    run(GA_RSVD, 32'd5, 32'd6, M_NORM, 0, 1, 1);
    err_echo = 1'b0;
    run(GA_SUB, 32'd10, 32'd3, M_NORM, 0, 0, 0);
    run(GA_MUL, 32'd7, 32'd9, M_NORM, 3, 2, 0);
    run(GA_DOT, 32'd1, 32'd2, M_TMO, 1, 0, 0);
    run(GA_ADD, 32'd8, 32'd8, M_KISSUE, 2, 0, 0);
    run(GA_ADD, 32'd9, 32'd1, M_KWAIT, 0, 3, 0);
    run(GA_SUB, 32'd4, 32'd2, M_KRESP, 0, 1, 0);
    instr_valid = 1'b1; kill = 1'b1;
    #1 chk("idle_kill_ready", instr_ready, 1'b0);
    step();
    instr_valid = 1'b0; kill = 1'b0;
    chk("idle_kill_busy", busy, 1'b0);
    chk("idle_kill_req", ga_req.valid, 1'b0);
    for (int n = 0; n < 40; n++) begin
      int mode, delay;
      ga_funct_e f;
      mode = $urandom_range(0, 4);
      f = ($urandom_range(0, 4) == 4) ? GA_RSVD : ga_funct_e'(3'($urandom_range(0, 3)));
      delay = (mode == M_KWAIT) ? $urandom_range(1, T - 2) : $urandom_range(0, T - 2);
      run(f, $urandom, $urandom, mode, $urandom_range(0, 3), delay, $urandom_range(0, 2));
    end
    instr_funct = GA_ADD; op_a = 32'd1; op_b = 32'd2; rd = 5'd3;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0; ga_resp.ready = 1'b1;
    step();
    ga_resp.ready = 1'b0;
    step();
    step();
    chk("mid_wait_busy", busy, 1'b1);
    rst_n = 1'b0;
    exp_issued = '0; exp_tmo = '0; exp_spur = '0;
    #1 chk_reset();
    step();
    rst_n = 1'b1;
    step();
    run(GA_ADD, 32'd20, 32'd22, M_NORM, 1, 1, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
